// File: rtl/nand_seq_pkg.sv
// Shared constants, state encoding and step-list helper for the NAND operation sequencer.
package nand_seq_pkg;

  localparam logic [7:0] CMD_RESET       = 8'h01;
  localparam logic [7:0] CMD_READ_ID     = 8'h03;
  localparam logic [7:0] CMD_DISABLE     = 8'h08;
  localparam logic [7:0] CMD_ENABLE      = 8'h09;
  localparam logic [7:0] CMD_GET_ID_BYTE = 8'h0e;

  localparam logic OP_RESET   = 1'b0;
  localparam logic OP_READ_ID = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT,
    ST_CAPTURE,
    ST_FINISH
  } state_t;

  // Index of the closing DISABLE step for a given operation.
  function automatic logic [4:0] last_step_idx(input logic op, input int id_bytes);
    return (op == OP_READ_ID) ? 5'(id_bytes + 2) : 5'd2;
  endfunction

endpackage

// File: rtl/nand_seq_step_rom.sv
// Maps (operation, step index) to the nand_master command and per-step attributes.
module nand_seq_step_rom
  import nand_seq_pkg::*;
#(
  parameter int ID_BYTES = 5
) (
  input  logic       op,
  input  logic [4:0] step,
  output logic [7:0] cmd,
  output logic       uses_addr,
  output logic       is_capture,
  output logic       is_last
);

  logic [4:0] last;

  assign last = last_step_idx(op, ID_BYTES);

  always_comb begin
    cmd        = 8'h00;
    uses_addr  = 1'b0;
    is_capture = 1'b0;
    is_last    = 1'b0;
    if (step == 5'd0) begin
      cmd = CMD_ENABLE;
    end else if (step == last) begin
      cmd     = CMD_DISABLE;
      is_last = 1'b1;
    end else if (op == OP_RESET) begin
      if (step == 5'd1) cmd = CMD_RESET;
    end else if (step == 5'd1) begin
      cmd       = CMD_READ_ID;
      uses_addr = 1'b1;
    end else if (step < last) begin
      cmd        = CMD_GET_ID_BYTE;
      is_capture = 1'b1;
    end
  end

endmodule

// File: rtl/nand_op_sequencer.sv
// Turns a single RESET / READ_ID request into the nand_master command sequence.
//
// state   | meaning
// IDLE    | waiting for req
// ISSUE   | nm_activate pulse for the current step
// GUARD   | skip nm_busy while nand_master raises it; arm timeout
// WAIT    | wait for nm_busy low or timeout
// CAPTURE | present one ID byte to the host
// FINISH  | done pulse with err, then back to IDLE
module nand_op_sequencer
  import nand_seq_pkg::*;
#(
  parameter int ID_BYTES = 5,
  parameter int TIMEOUT  = 4096,
  parameter int TW       = 13
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req,
  input  logic       op,
  input  logic [7:0] id_addr,
  output logic       ack,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       id_valid,
  output logic [7:0] id_byte,
  output logic       nm_activate,
  output logic [7:0] nm_cmd_in,
  output logic [7:0] nm_data_in,
  input  logic       nm_busy,
  input  logic [7:0] nm_data_out
);

  state_t        state;
  logic [4:0]    step;
  logic [3:0]    byte_cnt;
  logic          op_q;
  logic [7:0]    addr_q;
  logic          err_latch;
  logic          cur_capture;
  logic          cur_last;
  logic [TW-1:0] tmo_cnt;

  logic       op_sel;
  logic [7:0] addr_sel;
  logic [4:0] step_sel;
  logic [7:0] rom_cmd;
  logic       rom_uses_addr;
  logic       rom_is_capture;
  logic       rom_is_last;
  logic       tmo_hit;
  logic       do_issue;

  assign tmo_hit = (state == ST_WAIT) && nm_busy && (tmo_cnt == '0);

  // The ROM is addressed by the step about to be issued, so the command
  // registers are loaded on the same edge that enters ISSUE.
  always_comb begin
    op_sel   = op_q;
    addr_sel = addr_q;
    step_sel = step + 5'd1;
    if (state == ST_IDLE) begin
      op_sel   = op;
      addr_sel = id_addr;
      step_sel = 5'd0;
    end else if (tmo_hit) begin
      step_sel = last_step_idx(op_q, ID_BYTES);
    end
  end

  always_comb begin
    do_issue = 1'b0;
    case (state)
      ST_IDLE:    do_issue = req;
      ST_CAPTURE: do_issue = 1'b1;
      ST_WAIT:    do_issue = nm_busy ? (tmo_hit && !cur_last) : (!cur_capture && !cur_last);
      default:    do_issue = 1'b0;
    endcase
  end

  nand_seq_step_rom #(.ID_BYTES(ID_BYTES)) u_rom (
    .op         (op_sel),
    .step       (step_sel),
    .cmd        (rom_cmd),
    .uses_addr  (rom_uses_addr),
    .is_capture (rom_is_capture),
    .is_last    (rom_is_last)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      step        <= '0;
      byte_cnt    <= '0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      err_latch   <= 1'b0;
      cur_capture <= 1'b0;
      cur_last    <= 1'b0;
      tmo_cnt     <= '0;
      ack         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      id_valid    <= 1'b0;
      id_byte     <= '0;
      nm_activate <= 1'b0;
      nm_cmd_in   <= '0;
      nm_data_in  <= '0;
    end else begin
      ack         <= 1'b0;
      nm_activate <= 1'b0;
      id_valid    <= 1'b0;
      done        <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req) begin
            op_q      <= op;
            addr_q    <= id_addr;
            byte_cnt  <= '0;
            err_latch <= 1'b0;
            ack       <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_ISSUE: state <= ST_GUARD;
        ST_GUARD: begin
          tmo_cnt <= TW'(TIMEOUT - 1);
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!nm_busy) begin
            if (cur_capture) begin
              id_byte  <= nm_data_out;
              id_valid <= 1'b1;
              byte_cnt <= byte_cnt + 4'd1;
              state    <= ST_CAPTURE;
            end else if (cur_last) begin
              done  <= 1'b1;
              err   <= err_latch;
              state <= ST_FINISH;
            end
          end else if (tmo_cnt == '0) begin
            err_latch <= 1'b1;
            if (cur_last) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= ST_FINISH;
            end
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        ST_CAPTURE: state <= ST_ISSUE;
        ST_FINISH: begin
          busy       <= 1'b0;
          err        <= 1'b0;
          err_latch  <= 1'b0;
          nm_cmd_in  <= '0;
          nm_data_in <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (do_issue) begin
        nm_activate <= 1'b1;
        nm_cmd_in   <= rom_cmd;
        nm_data_in  <= rom_uses_addr ? addr_sel : 8'h00;
        step        <= step_sel;
        cur_capture <= rom_is_capture;
        cur_last    <= rom_is_last;
        state       <= ST_ISSUE;
      end
    end
  end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Directed bench for nand_op_sequencer with a behavioural nand_master stand-in.
module tb_nand_op_sequencer;
  import nand_seq_pkg::*;

  localparam int ID_BYTES = 5;
  localparam int TIMEOUT  = 16;
  localparam int TW       = 13;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       req = 1'b0;
  logic       op = 1'b0;
  logic [7:0] id_addr = 8'h00;
  logic       ack, busy, done, err, id_valid;
  logic [7:0] id_byte;
  logic       nm_activate;
  logic [7:0] nm_cmd_in, nm_data_in;
  logic       nm_busy;
  logic [7:0] nm_data_out;

  nand_op_sequencer #(.ID_BYTES(ID_BYTES), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .req         (req),
    .op          (op),
    .id_addr     (id_addr),
    .ack         (ack),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .id_valid    (id_valid),
    .id_byte     (id_byte),
    .nm_activate (nm_activate),
    .nm_cmd_in   (nm_cmd_in),
    .nm_data_in  (nm_data_in),
    .nm_busy     (nm_busy),
    .nm_data_out (nm_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // nand_master stand-in: busy rises the cycle after activate, stuck from a chosen command on
  logic [7:0] id_tbl [5] = '{8'h2c, 8'he5, 8'hff, 8'h03, 8'h86};
  int   mock_busy_len = 0;
  int   mock_stuck_from = -1;
  logic mock_rst = 1'b0;
  int   m_cnt = 0, m_idx = 0, m_gid = 0;

  always @(posedge clk) begin
    if (mock_rst) begin
      m_cnt <= 0; m_idx <= 0; m_gid <= 0; nm_data_out <= 8'h00;
    end else if (nm_activate) begin
      m_idx <= m_idx + 1;
      if (mock_stuck_from >= 0 && m_idx >= mock_stuck_from) m_cnt <= 1000000;
      else m_cnt <= mock_busy_len;
      if (nm_cmd_in == CMD_GET_ID_BYTE) begin
        nm_data_out <= id_tbl[m_gid % 5];
        m_gid <= m_gid + 1;
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign nm_busy = (m_cnt != 0);

  logic [7:0] cmd_q[$], din_q[$], byte_q[$];
  int         act_cyc_q[$], ack_cyc_q[$], done_cyc_q[$];
  logic       err_q[$], busy_done_q[$];

  always @(negedge clk) begin
    if (nm_activate) begin cmd_q.push_back(nm_cmd_in); din_q.push_back(nm_data_in); act_cyc_q.push_back(cyc); end
    if (ack) ack_cyc_q.push_back(cyc);
    if (id_valid) byte_q.push_back(id_byte);
    if (done) begin done_cyc_q.push_back(cyc); err_q.push_back(err); busy_done_q.push_back(busy); end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic            op;
    logic [7:0]      addr;
    int              busy_len;
    int              stuck_from;
    logic            harass;
    int              n_cmds;
    logic [0:7][7:0] cmds;
    int              n_bytes;
    logic            exp_err;
  } vec_t;

  function automatic vec_t mk(input logic o, input logic [7:0] a, input int bl, input int st,
                              input logic h, input int n, input logic [63:0] c, input int nb,
                              input logic e);
    vec_t v;
    v.op = o; v.addr = a; v.busy_len = bl; v.stuck_from = st; v.harass = h;
    v.n_cmds = n; v.cmds = c; v.n_bytes = nb; v.exp_err = e;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int   c0, a0, b0, d0, req_cyc, nc, nb, ni;
    logic got_done;
    logic [7:0] exp_din;
    c0 = cmd_q.size(); a0 = ack_cyc_q.size(); b0 = byte_q.size(); d0 = done_cyc_q.size();
    mock_busy_len = v.busy_len;
    mock_stuck_from = v.stuck_from;
    mock_rst = 1'b1;
    @(negedge clk);
    mock_rst = 1'b0;
    req = 1'b1; op = v.op; id_addr = v.addr; req_cyc = cyc;
    @(negedge clk);
    req = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_cyc_q.size() > d0) begin got_done = 1'b1; break; end
      if (v.harass) begin req = (i % 5 == 2); op = ~v.op; id_addr = 8'h55; end
    end
    req = 1'b0;
    if (!got_done) begin
      chk({tag, " done_seen"}, 0, 1);
      return;
    end
    repeat (2) @(negedge clk);
    chk({tag, " busy_after_done"}, int'(busy), 0);
    chk({tag, " ack_count"}, ack_cyc_q.size() - a0, 1);
    chk({tag, " ack_cycle"}, ack_cyc_q[a0], req_cyc + 1);
    chk({tag, " done_count"}, done_cyc_q.size() - d0, 1);
    chk({tag, " err"}, int'(err_q[d0]), int'(v.exp_err));
    chk({tag, " busy_at_done"}, int'(busy_done_q[d0]), 1);
    nc = cmd_q.size() - c0;
    chk({tag, " cmd_count"}, nc, v.n_cmds);
    for (int k = 0; k < nc && k < v.n_cmds; k++) begin
      exp_din = (v.cmds[k] == CMD_READ_ID) ? v.addr : 8'h00;
      chk($sformatf("%s cmd[%0d]", tag, k), int'(cmd_q[c0 + k]), int'(v.cmds[k]));
      chk($sformatf("%s din[%0d]", tag, k), int'(din_q[c0 + k]), int'(exp_din));
    end
    nb = byte_q.size() - b0;
    chk({tag, " byte_count"}, nb, v.n_bytes);
    for (int k = 0; k < nb && k < v.n_bytes; k++)
      chk($sformatf("%s id_byte[%0d]", tag, k), int'(byte_q[b0 + k]), int'(id_tbl[k]));
    if (v.busy_len == 0 && v.stuck_from < 0) begin
      chk({tag, " act0_with_ack"}, act_cyc_q[c0], ack_cyc_q[a0]);
      for (int k = 1; k < nc && k < v.n_cmds; k++)
        chk($sformatf("%s act_gap[%0d]", tag, k), act_cyc_q[c0 + k] - act_cyc_q[c0 + k - 1],
            (v.cmds[k - 1] == CMD_GET_ID_BYTE) ? 4 : 3);
      ni = 3 * v.n_cmds + v.n_bytes;
      chk({tag, " ack_to_done"}, done_cyc_q[d0] - ack_cyc_q[a0], ni);
    end
  endtask

  vec_t vecs[6];

  initial begin
    int b0;
    logic got;
    vecs[0] = mk(OP_READ_ID, 8'h00, 10, -1, 1'b0, 8, 64'h09_03_0e_0e_0e_0e_0e_08, 5, 1'b0);
    vecs[1] = mk(OP_RESET,   8'h00,  0, -1, 1'b0, 3, 64'h09_01_08_00_00_00_00_00, 0, 1'b0);
    vecs[2] = mk(OP_READ_ID, 8'h20,  2, -1, 1'b0, 8, 64'h09_03_0e_0e_0e_0e_0e_08, 5, 1'b0);
    vecs[3] = mk(OP_READ_ID, 8'h00,  3,  3, 1'b0, 5, 64'h09_03_0e_0e_08_00_00_00, 1, 1'b1);
    vecs[4] = mk(OP_READ_ID, 8'h00,  3, -1, 1'b1, 8, 64'h09_03_0e_0e_0e_0e_0e_08, 5, 1'b0);
    vecs[5] = mk(OP_RESET,   8'h00,  4, -1, 1'b0, 3, 64'h09_01_08_00_00_00_00_00, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("reset ack", int'(ack), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset activate", int'(nm_activate), 0);
    chk("reset cmd", int'(nm_cmd_in), 0);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while waiting on a GET_ID_BYTE command
    b0 = byte_q.size();
    mock_busy_len = 10; mock_stuck_from = -1;
    mock_rst = 1'b1; @(negedge clk); mock_rst = 1'b0;
    req = 1'b1; op = OP_READ_ID; id_addr = 8'h00;
    @(negedge clk); req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (byte_q.size() > b0) begin got = 1'b1; break; end
    end
    chk("midrst first_byte_seen", int'(got), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("midrst busy_before", int'(busy), 1);
    chk("midrst cmd_before", int'(nm_cmd_in), int'(CMD_GET_ID_BYTE));
    #1 nreset = 1'b0;
    #1;
    chk("midrst ack", int'(ack), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst err", int'(err), 0);
    chk("midrst id_valid", int'(id_valid), 0);
    chk("midrst id_byte", int'(id_byte), 0);
    chk("midrst activate", int'(nm_activate), 0);
    chk("midrst cmd", int'(nm_cmd_in), 0);
    chk("midrst din", int'(nm_data_in), 0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(vecs[1], "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
